// File: rtl/beep_the_east_is_red.sv
// Passive-buzzer player for "The East Is Red": a 20-step note/duration table drives a square wave.
// Define BEEP_LOOP_EN to repeat the melody forever; otherwise playback stops after step 19.
module beep_the_east_is_red #(
  parameter int unsigned time_1s    = 49_999_999,
  parameter int unsigned time_500ms = 24_999_999,
  parameter int unsigned DO         = 190_839,
  parameter int unsigned RE         = 170_068,
  parameter int unsigned MI         = 151_515,
  parameter int unsigned FA         = 143_266,
  parameter int unsigned SO         = 127_551,
  parameter int unsigned LA         = 113_636,
  parameter int unsigned XI         = 101_214,
  parameter int unsigned DOO        = 95_420
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic beep
);

  localparam logic [4:0] LastStep = 5'd19;

  logic [4:0]  step_q, step_d;
  logic [31:0] dur_q, dur_d;
  logic [31:0] note_q, note_d;
  logic        done_q, done_d;
  logic        beep_q, beep_d;

  logic [31:0] period;
  logic [31:0] half;
  logic [31:0] limit;
  logic        is_long;
  logic        note_wrap;
  logic [31:0] xi_unused;

  // XI is part of the note set but never appears in this melody.
  assign xi_unused = XI;

  always_comb begin
    period  = SO;
    is_long = 1'b1;
    unique case (step_q)
      5'd0:    begin period = SO;  is_long = 1'b1; end
      5'd1:    begin period = SO;  is_long = 1'b0; end
      5'd2:    begin period = LA;  is_long = 1'b0; end
      5'd3:    begin period = RE;  is_long = 1'b1; end
      5'd4:    begin period = DO;  is_long = 1'b1; end
      5'd5:    begin period = DO;  is_long = 1'b0; end
      5'd6:    begin period = LA;  is_long = 1'b0; end
      5'd7:    begin period = RE;  is_long = 1'b1; end
      5'd8:    begin period = SO;  is_long = 1'b1; end
      5'd9:    begin period = SO;  is_long = 1'b0; end
      5'd10:   begin period = LA;  is_long = 1'b0; end
      5'd11:   begin period = DOO; is_long = 1'b0; end
      5'd12:   begin period = LA;  is_long = 1'b0; end
      5'd13:   begin period = SO;  is_long = 1'b0; end
      5'd14:   begin period = DO;  is_long = 1'b1; end
      5'd15:   begin period = RE;  is_long = 1'b1; end
      5'd16:   begin period = SO;  is_long = 1'b0; end
      5'd17:   begin period = FA;  is_long = 1'b0; end
      5'd18:   begin period = MI;  is_long = 1'b0; end
      5'd19:   begin period = RE;  is_long = 1'b1; end
      default: begin period = SO;  is_long = 1'b1; end
    endcase
  end

  assign half      = period >> 1;
  assign limit     = is_long ? time_1s : time_500ms;
  // Periods of 0 or 1 pin the counter at 0; half is 0 so beep stays low.
  assign note_wrap = (period <= 32'd1) || (note_q >= period - 32'd1);

  always_comb begin
    step_d = step_q;
    dur_d  = dur_q;
    note_d = note_q;
    done_d = done_q;
    beep_d = 1'b0;
    if (!enable) begin
      step_d = '0;
      dur_d  = '0;
      note_d = '0;
      done_d = 1'b0;
    end else if (!done_q) begin
      beep_d = (note_q < half);
      if (dur_q >= limit) begin
        dur_d  = '0;
        note_d = '0;
        if (step_q == LastStep) begin
          step_d = '0;
`ifdef BEEP_LOOP_EN
          done_d = 1'b0;
`else
          done_d = 1'b1;
`endif
        end else begin
          step_d = step_q + 5'd1;
        end
      end else begin
        dur_d  = dur_q + 32'd1;
        note_d = note_wrap ? 32'd0 : note_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      dur_q  <= '0;
      note_q <= '0;
      done_q <= 1'b0;
      beep_q <= 1'b0;
    end else begin
      step_q <= step_d;
      dur_q  <= dur_d;
      note_q <= note_d;
      done_q <= done_d;
      beep_q <= beep_d;
    end
  end

  assign beep = beep_q;

endmodule

// File: tb/tb_beep_the_east_is_red.sv
// Directed bench for beep_the_east_is_red with shortened note/duration parameters.
// Compile with BEEP_LOOP_EN defined to exercise the looping end-of-melody behaviour.
module tb_beep_the_east_is_red;

  logic clk;
  logic rst_n;
  logic enable;
  logic beep;

  int checks;
  int failures;
  int cyc;

  beep_the_east_is_red #(
    .time_1s   (499),
    .time_500ms(249),
    .DO        (190),
    .RE        (170),
    .MI        (151),
    .FA        (143),
    .SO        (127),
    .LA        (113),
    .XI        (101),
    .DOO       (95)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .beep  (beep)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto_cyc(input int target);
    while (cyc < target) tick();
  endtask

  // Length of the run of beep == lvl starting at the current sample, bounded.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (beep == lvl && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic check_runs(input string tag, input int hi, input int lo);
    int n;
    run_len(1'b1, n);
    check_eq({tag, "_high"}, n, hi);
    run_len(1'b0, n);
    check_eq({tag, "_low"}, n, lo);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_n    = 1'b1;
    enable   = 1'b1;
    #1 rst_n = 1'b0;
    #4 check_eq("beep_in_reset_early", int'(beep), 0);
    @(negedge clk);
    check_eq("beep_in_reset", int'(beep), 0);
    rst_n = 1'b1;
    cyc   = 0;

    // Step 0: SO, 500 cycles -> H63 L64 repeating, truncated at the end.
    tick();
    check_eq("step0_first_high", int'(beep), 1);
    check_runs("step0_p1", 63, 64);
    check_runs("step0_p2", 63, 64);
    goto_cyc(500);
    check_eq("step0_last_cycle", int'(beep), 0);
    tick();
    check_eq("step1_start_high", int'(beep), 1);
    check_runs("step1_so", 63, 64);
    goto_cyc(751);
    check_runs("step2_la", 56, 57);
    goto_cyc(1001);
    check_runs("step3_re", 85, 85);

    // Drop enable in the middle of step 5 (cycles 2001..2250).
    goto_cyc(2100);
    enable = 1'b0;
    tick();
    check_eq("enable_low_next_edge", int'(beep), 0);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (beep) n++;
    end
    check_eq("enable_low_silent", n, 0);
    enable = 1'b1;
    cyc    = 0;
    tick();
    check_eq("restart_first_high", int'(beep), 1);
    check_runs("restart_so", 63, 64);
    goto_cyc(500);
    check_eq("restart_step0_end", int'(beep), 0);
    tick();
    check_eq("restart_step1_start", int'(beep), 1);

    // Step 11: DOO occupies cycles 4001..4250.
    goto_cyc(4001);
    check_runs("step11_doo_p1", 47, 48);
    check_runs("step11_doo_p2", 47, 48);

    goto_cyc(7000);
    check_eq("step19_last_cycle", int'(beep), 0);
`ifdef BEEP_LOOP_EN
    tick();
    check_eq("loop_restart_high", int'(beep), 1);
    check_runs("loop_so", 63, 64);
`else
    n = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (beep) n++;
    end
    check_eq("done_silent", n, 0);
    enable = 1'b0;
    tick();
    check_eq("done_enable_low", int'(beep), 0);
    enable = 1'b1;
    cyc    = 0;
    tick();
    check_eq("replay_first_high", int'(beep), 1);
    check_runs("replay_so", 63, 64);
`endif

    // Async reset in the middle of a high phase, between clock edges.
    check_eq("pre_async_high", int'(beep), 1);
    #5 rst_n = 1'b0;
    #1 check_eq("async_reset_immediate", int'(beep), 0);
    @(negedge clk);
    tick();
    check_eq("async_reset_held", int'(beep), 0);
    rst_n = 1'b1;
    cyc   = 0;
    tick();
    check_eq("post_reset_first_high", int'(beep), 1);
    check_runs("post_reset_so", 63, 64);
    goto_cyc(500);
    check_eq("post_reset_step0_end", int'(beep), 0);
    tick();
    check_eq("post_reset_step1_start", int'(beep), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
